// File: rtl/msi_line_ctrl.sv
// MSI coherence controller for a small direct-mapped cache: tracks per-line state/tag,
// serves CPU hits, issues bus misses/upgrades with optional victim write-back, and reacts to snoops.
module msi_line_ctrl #(
  parameter  int NUM_LINES = 4,
  parameter  int TAG_W     = 4,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int ADDR_W    = TAG_W + IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic              bus_req,
  output logic [1:0]        bus_msg,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_grant,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_msg,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_wb
);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_M = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;

  localparam logic [1:0] MSG_RD   = 2'b00;
  localparam logic [1:0] MSG_WR   = 2'b01;
  localparam logic [1:0] MSG_INV  = 2'b10;
  localparam logic [1:0] MSG_NONE = 2'b11;

  typedef enum logic [1:0] {IDLE, WB, BUS, DONE} fsm_t;

  fsm_t              fsm_q;
  logic              reqWrite_q;
  logic [ADDR_W-1:0] reqAddr_q;
  logic [1:0]        lineState_q [NUM_LINES];
  logic [TAG_W-1:0]  lineTag_q   [NUM_LINES];

  logic [IDX_W-1:0]  cpuIdx;
  logic [TAG_W-1:0]  cpuTag;
  logic [1:0]        cpuLineState;
  logic [TAG_W-1:0]  cpuLineTag;
  logic              cpuLineHit;
  logic [IDX_W-1:0]  snpIdx;
  logic [TAG_W-1:0]  snpTag;
  logic              snpHit;
  logic [IDX_W-1:0]  reqIdx;
  logic [TAG_W-1:0]  reqTag;
  logic              grantNow;
  logic              snpApply;
  logic              snpKillsPending;

  assign cpuIdx       = cpu_addr[IDX_W-1:0];
  assign cpuTag       = cpu_addr[ADDR_W-1:IDX_W];
  assign cpuLineState = lineState_q[cpuIdx];
  assign cpuLineTag   = lineTag_q[cpuIdx];
  assign cpuLineHit   = (cpuLineState != ST_I) && (cpuLineTag == cpuTag);

  assign snpIdx = snoop_addr[IDX_W-1:0];
  assign snpTag = snoop_addr[ADDR_W-1:IDX_W];
  assign snpHit = snoop_valid && (lineState_q[snpIdx] != ST_I) && (lineTag_q[snpIdx] == snpTag);

  assign reqIdx   = reqAddr_q[IDX_W-1:0];
  assign reqTag   = reqAddr_q[ADDR_W-1:IDX_W];
  assign grantNow = (fsm_q == BUS) && bus_grant;

  // Our own granted fill owns the line this cycle, so a coinciding snoop on that index is dropped.
  assign snpApply = snpHit && !(grantNow && (snpIdx == reqIdx));

  // A pending upgrade whose S copy is stolen must now fetch the line as a write miss.
  assign snpKillsPending = snpApply && (fsm_q == BUS) && (bus_msg == MSG_INV) &&
                           ((snoop_msg == MSG_WR) || (snoop_msg == MSG_INV)) &&
                           (snoop_addr == reqAddr_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lineState_q[i] <= ST_I;
        lineTag_q[i]   <= '0;
      end
      fsm_q      <= IDLE;
      reqWrite_q <= 1'b0;
      reqAddr_q  <= '0;
      cpu_ready  <= 1'b0;
      cpu_hit    <= 1'b0;
      bus_req    <= 1'b0;
      bus_msg    <= MSG_NONE;
      bus_addr   <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      snoop_wb   <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      wb_valid  <= 1'b0;
      snoop_wb  <= 1'b0;

      if (snpApply) begin
        case (snoop_msg)
          MSG_RD: begin
            if (lineState_q[snpIdx] == ST_M) begin
              lineState_q[snpIdx] <= ST_S;
              snoop_wb            <= 1'b1;
            end
          end
          MSG_WR: begin
            if (lineState_q[snpIdx] == ST_M) snoop_wb <= 1'b1;
            lineState_q[snpIdx] <= ST_I;
          end
          MSG_INV: lineState_q[snpIdx] <= ST_I;
          default: ;
        endcase
      end

      case (fsm_q)
        IDLE: begin
          if (cpu_valid) begin
            reqWrite_q <= cpu_write;
            reqAddr_q  <= cpu_addr;
            if (cpuLineHit && (!cpu_write || (cpuLineState == ST_M))) begin
              cpu_ready <= 1'b1;
              cpu_hit   <= 1'b1;
            end else if (cpuLineHit) begin
              fsm_q    <= BUS;
              bus_req  <= 1'b1;
              bus_msg  <= MSG_INV;
              bus_addr <= cpu_addr;
            end else if (cpuLineState == ST_M) begin
              fsm_q    <= WB;
              wb_valid <= 1'b1;
              wb_addr  <= {cpuLineTag, cpuIdx};
            end else begin
              fsm_q    <= BUS;
              bus_req  <= 1'b1;
              bus_msg  <= cpu_write ? MSG_WR : MSG_RD;
              bus_addr <= cpu_addr;
            end
          end
        end
        WB: begin
          fsm_q    <= BUS;
          bus_req  <= 1'b1;
          bus_msg  <= reqWrite_q ? MSG_WR : MSG_RD;
          bus_addr <= reqAddr_q;
        end
        BUS: begin
          if (bus_grant) begin
            lineState_q[reqIdx] <= (bus_msg == MSG_RD) ? ST_S : ST_M;
            lineTag_q[reqIdx]   <= reqTag;
            bus_req             <= 1'b0;
            bus_msg             <= MSG_NONE;
            fsm_q               <= DONE;
          end else if (snpKillsPending) begin
            bus_msg <= MSG_WR;
          end
        end
        DONE: begin
          cpu_ready <= 1'b1;
          cpu_hit   <= 1'b0;
          fsm_q     <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msi_line_ctrl.sv
// Directed bench for msi_line_ctrl: CPU completions are scored against a queue of expected
// hit/miss results; bus, write-back, snoop and line-state effects are checked at each step.
module tb_msi_line_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_valid = 1'b0;
  logic       cpu_write = 1'b0;
  logic [5:0] cpu_addr = '0;
  logic       cpu_ready;
  logic       cpu_hit;
  logic       bus_req;
  logic [1:0] bus_msg;
  logic [5:0] bus_addr;
  logic       bus_grant = 1'b0;
  logic       wb_valid;
  logic [5:0] wb_addr;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_msg = 2'b11;
  logic [5:0] snoop_addr = '0;
  logic       snoop_wb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    logic  hit;
  } expT;
  expT expQ[$];

  msi_line_ctrl #(.NUM_LINES(4), .TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
    .bus_req(bus_req), .bus_msg(bus_msg), .bus_addr(bus_addr), .bus_grant(bus_grant),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .snoop_valid(snoop_valid), .snoop_msg(snoop_msg), .snoop_addr(snoop_addr),
    .snoop_wb(snoop_wb)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic wr, input logic [5:0] addr, input logic expHit);
    expT e;
    e.tag = tag;
    e.hit = expHit;
    expQ.push_back(e);
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_addr  = addr;
    tick();
    cpu_valid = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic waitReady(input int budget);
    expT e;
    bit  seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (cpu_ready) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("[TB] FAIL ready_timeout: observed no cpu_ready expected a pulse within %0d cycles", budget);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end else begin
      e = expQ.pop_front();
      checkOutput({e.tag, "_hit"}, cpu_hit, e.hit);
      tick();
      checkOutput({e.tag, "_readyOneCycle"}, cpu_ready, 0);
    end
  endtask

  task automatic applySnoop(input logic [1:0] msg, input logic [5:0] addr);
    snoop_valid = 1'b1;
    snoop_msg   = msg;
    snoop_addr  = addr;
    tick();
    snoop_valid = 1'b0;
    snoop_msg   = 2'b11;
  endtask

  task automatic grantAndComplete();
    bus_grant = 1'b1;
    waitReady(10);
    bus_grant = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_cpuReady", cpu_ready, 0);
    checkOutput("rst_cpuHit", cpu_hit, 0);
    checkOutput("rst_busReq", bus_req, 0);
    checkOutput("rst_busMsg", bus_msg, 2'b11);
    checkOutput("rst_busAddr", bus_addr, 0);
    checkOutput("rst_wbValid", wb_valid, 0);
    checkOutput("rst_wbAddr", wb_addr, 0);
    checkOutput("rst_snoopWb", snoop_wb, 0);
    checkOutput("rst_line1", dut.lineState_q[1], 2'b00);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Read miss with grant already high, then re-read hits.
    bus_grant = 1'b1;
    applyStimulus("rdMiss05", 1'b0, 6'h05, 1'b0);
    checkOutput("rdMiss05_busReq", bus_req, 1);
    checkOutput("rdMiss05_busMsg", bus_msg, 2'b00);
    checkOutput("rdMiss05_busAddr", bus_addr, 6'h05);
    waitReady(10);
    bus_grant = 1'b0;
    checkOutput("rdMiss05_lineState", dut.lineState_q[1], 2'b10);
    checkOutput("rdMiss05_lineTag", dut.lineTag_q[1], 4'h1);
    checkOutput("idle_busMsg", bus_msg, 2'b11);
    checkOutput("idle_busAddrHeld", bus_addr, 6'h05);
    applyStimulus("rdHit05", 1'b0, 6'h05, 1'b1);
    checkOutput("rdHit05_nextCycle", cpu_ready, 1);
    waitReady(10);

    // Write hit on S becomes an upgrade held until granted.
    applyStimulus("wrUpg05", 1'b1, 6'h05, 1'b0);
    checkOutput("wrUpg05_busMsg", bus_msg, 2'b10);
    checkOutput("wrUpg05_busAddr", bus_addr, 6'h05);
    tick();
    checkOutput("wrUpg05_busReqHeld", bus_req, 1);
    checkOutput("wrUpg05_busMsgHeld", bus_msg, 2'b10);
    grantAndComplete();
    checkOutput("wrUpg05_lineState", dut.lineState_q[1], 2'b01);
    applyStimulus("wrHit05", 1'b1, 6'h05, 1'b1);
    checkOutput("wrHit05_nextCycle", cpu_ready, 1);
    waitReady(10);

    // Miss on a Modified victim writes it back first.
    applyStimulus("rdMiss09", 1'b0, 6'h09, 1'b0);
    checkOutput("rdMiss09_wbValid", wb_valid, 1);
    checkOutput("rdMiss09_wbAddr", wb_addr, 6'h05);
    checkOutput("rdMiss09_noBusYet", bus_req, 0);
    tick();
    checkOutput("rdMiss09_wbOneCycle", wb_valid, 0);
    checkOutput("rdMiss09_busReq", bus_req, 1);
    checkOutput("rdMiss09_busMsg", bus_msg, 2'b00);
    checkOutput("rdMiss09_busAddr", bus_addr, 6'h09);
    grantAndComplete();
    checkOutput("rdMiss09_lineState", dut.lineState_q[1], 2'b10);
    checkOutput("rdMiss09_lineTag", dut.lineTag_q[1], 4'h2);
    checkOutput("idle_wbAddrHeld", wb_addr, 6'h05);

    // Snoops on a Modified line.
    applyStimulus("wrMiss0E", 1'b1, 6'h0E, 1'b0);
    checkOutput("wrMiss0E_busMsg", bus_msg, 2'b01);
    checkOutput("wrMiss0E_busAddr", bus_addr, 6'h0E);
    grantAndComplete();
    checkOutput("wrMiss0E_lineState", dut.lineState_q[2], 2'b01);
    applySnoop(2'b00, 6'h0E);
    checkOutput("snpRd0E_snoopWb", snoop_wb, 1);
    checkOutput("snpRd0E_lineState", dut.lineState_q[2], 2'b10);
    tick();
    checkOutput("snpRd0E_wbOneCycle", snoop_wb, 0);
    applySnoop(2'b01, 6'h0E);
    checkOutput("snpWr0E_noSnoopWb", snoop_wb, 0);
    checkOutput("snpWr0E_lineState", dut.lineState_q[2], 2'b00);

    // Pending upgrade turned into a write miss by a snoop invalidate.
    applyStimulus("rdMiss05b", 1'b0, 6'h05, 1'b0);
    checkOutput("rdMiss05b_noWb", wb_valid, 0);
    checkOutput("rdMiss05b_busMsg", bus_msg, 2'b00);
    grantAndComplete();
    applyStimulus("wrUpg05b", 1'b1, 6'h05, 1'b0);
    checkOutput("wrUpg05b_busMsg", bus_msg, 2'b10);
    applySnoop(2'b10, 6'h05);
    checkOutput("wrUpg05b_convertedMsg", bus_msg, 2'b01);
    checkOutput("wrUpg05b_busReq", bus_req, 1);
    checkOutput("wrUpg05b_lineInvalid", dut.lineState_q[1], 2'b00);
    grantAndComplete();
    checkOutput("wrUpg05b_lineState", dut.lineState_q[1], 2'b01);
    checkOutput("wrUpg05b_lineTag", dut.lineTag_q[1], 4'h1);

    // Invalidate on a Modified line drops it without a write-back.
    applySnoop(2'b10, 6'h05);
    checkOutput("snpInv05_noSnoopWb", snoop_wb, 0);
    checkOutput("snpInv05_lineState", dut.lineState_q[1], 2'b00);

    // Grant coinciding with a snoop on the same index: own transaction wins.
    applyStimulus("wrMiss05", 1'b1, 6'h05, 1'b0);
    checkOutput("wrMiss05_busMsg", bus_msg, 2'b01);
    grantAndComplete();
    applyStimulus("rdMiss0D", 1'b0, 6'h0D, 1'b0);
    checkOutput("rdMiss0D_wbAddr", wb_addr, 6'h05);
    tick();
    checkOutput("rdMiss0D_busAddr", bus_addr, 6'h0D);
    bus_grant = 1'b1;
    applySnoop(2'b00, 6'h05);
    bus_grant = 1'b0;
    checkOutput("collide_noSnoopWb", snoop_wb, 0);
    checkOutput("collide_lineState", dut.lineState_q[1], 2'b10);
    checkOutput("collide_lineTag", dut.lineTag_q[1], 4'h3);
    waitReady(10);

    // Reset while waiting on the bus abandons the transaction.
    applyStimulus("rdMiss02", 1'b0, 6'h02, 1'b0);
    checkOutput("rdMiss02_busReq", bus_req, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midRst_busReq", bus_req, 0);
    checkOutput("midRst_busMsg", bus_msg, 2'b11);
    checkOutput("midRst_busAddr", bus_addr, 0);
    checkOutput("midRst_line1", dut.lineState_q[1], 2'b00);
    checkOutput("midRst_line1Tag", dut.lineTag_q[1], 0);
    expQ.delete();
    bus_grant = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("midRst_noReady", cpu_ready, 0);
    end
    bus_grant = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msi_line_ctrl.md
MSI_LINE_CTRL -- requirements
Module: msi_line_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 4, meaning the number of direct-mapped cache lines (power of two, >=2).
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the tag width; IDX_W = clog2(NUM_LINES); ADDR_W = TAG_W+IDX_W; address = {tag, idx}.
REQ-003 The block SHALL have port clock  input  1  the single clock, rising-edge active.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port cpu_valid  input  1  CPU request present.
REQ-006 The block SHALL have port cpu_write  input  1  1 = write, 0 = read.
REQ-007 The block SHALL have port cpu_addr  input  ADDR_W  CPU request address.
REQ-008 The block SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have port cpu_hit  output  1  qualifies cpu_ready; 1 = completed as hit.
REQ-010 The block SHALL have port bus_req  output  1  bus request, held until granted.
REQ-011 The block SHALL have port bus_msg  output  2  00 read miss, 01 write miss, 10 invalidate, 11 none.
REQ-012 The block SHALL have port bus_addr  output  ADDR_W  address of the bus message.
REQ-013 The block SHALL have port bus_grant  input  1  bus granted; completes the transaction.
REQ-014 The block SHALL have port wb_valid  output  1  one-cycle victim write-back pulse.
REQ-015 The block SHALL have port wb_addr  output  ADDR_W  address {old tag, idx} of the victim.
REQ-016 The block SHALL have port snoop_valid  input  1  snooped bus message present.
REQ-017 The block SHALL have port snoop_msg  input  2  same encoding as bus_msg.
REQ-018 The block SHALL have port snoop_addr  input  ADDR_W  snooped address.
REQ-019 The block SHALL have port snoop_wb  output  1  one-cycle pulse: a snoop hit a Modified line, so supply or write back the data.

Function
REQ-020 Each line SHALL hold a 2-bit state (I=00, M=01, S=10) and a TAG_W tag; hit = state!=I and tag equal.
REQ-021 The controller FSM SHALL have states IDLE, WB, BUS and DONE.
REQ-022 In IDLE with cpu_valid=1, the controller SHALL latch cpu_write and cpu_addr; cpu_valid is ignored outside IDLE.
REQ-023 A read hit (S or M) or a write hit on M SHALL pulse cpu_ready=1 with cpu_hit=1 on the next cycle, with no state change; the FSM stays in IDLE.
REQ-024 A write hit on S SHALL go to BUS with bus_msg=10.
REQ-025 A miss whose victim line is in M SHALL go to WB: wb_valid=1 and wb_addr={victim tag, idx} for exactly one cycle, then BUS.
REQ-026 Any other miss SHALL go directly to BUS, with bus_msg=00 for a read or 01 for a write.
REQ-027 In BUS, bus_req=1 and bus_msg/bus_addr SHALL be held stable until bus_grant=1 is sampled.
REQ-028 On that grant edge the line SHALL take the new tag and state S (read) or M (write/invalidate), and the FSM SHALL go to DONE.
REQ-029 DONE SHALL pulse cpu_ready=1 with cpu_hit=0 for one cycle, then return to IDLE; miss latency is 2 cycles after grant or more.
REQ-030 Snoops SHALL be processed every cycle independent of FSM state, and only on an address hit.
REQ-031 Snoop read miss on M SHALL move the line to S with snoop_wb pulsed next cycle; snoop read miss on S SHALL cause no change.
REQ-032 Snoop write miss on M SHALL move the line to I with snoop_wb pulsed; snoop write miss or invalidate on S SHALL move the line to I.
REQ-033 Snoop invalidate on M SHALL move the line to I without snoop_wb.
REQ-034 If, in BUS with bus_msg=10 and no grant yet, a snoop invalidates the pending line, bus_msg SHALL become 01 on the next cycle (upgrade converted to write miss).
REQ-035 If snoop_valid and bus_grant coincide on the same index, the own transaction SHALL win and the snoop SHALL be ignored for that line.
REQ-036 When idle, bus_msg SHALL be 11, and bus_addr and wb_addr SHALL hold their last values.

Reset
REQ-037 Asserting reset SHALL immediately force all lines to I with tag 0, the FSM to IDLE, and cpu_ready, cpu_hit, bus_req, wb_valid and snoop_wb to 0, bus_msg to 11, and bus_addr and wb_addr to 0.
REQ-038 Reset mid-transaction SHALL abandon the transaction with no cpu_ready; bus_req SHALL drop asynchronously.

Verification (NUM_LINES=4, TAG_W=4)
REQ-039 After reset, read 0x05 with bus_grant held high -> bus_msg=00 and bus_addr=0x05; line 1 becomes S/tag 1; cpu_ready=1, cpu_hit=0; a re-read of 0x05 -> cpu_ready next cycle with cpu_hit=1.
REQ-040 With line 1 in S/tag 1, write 0x05 -> bus_msg=10; grant -> line 1 becomes M; cpu_ready with cpu_hit=0.
REQ-041 With line 1 in M/tag 1, read 0x09 -> wb_valid=1 with wb_addr=0x05 for one cycle, then bus_msg=00 with bus_addr=0x09; line 1 becomes S/tag 2.
REQ-042 With line 2 in M/tag 3, snoop read miss 0x0E -> snoop_wb=1 and line 2 becomes S; then snoop write miss 0x0E -> line 2 becomes I with no snoop_wb.
REQ-043 Pending upgrade on 0x05 with bus_grant=0, snoop invalidate 0x05 -> bus_msg changes 10 to 01; grant -> line 1 becomes M.
REQ-044 Reset asserted while in BUS -> bus_req=0 immediately, all lines I, and no cpu_ready pulse.
